// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: FSM states, detector run length and rotating winner select shared by seq_scan_arbiter.
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int RUN_MATCH_LEN = 3;
  localparam int MAX_REQ = 8;
  function automatic int pick_winner(input logic [MAX_REQ-1:0] req, input int n, input int start);
    int w;
    int idx;
    logic found;
    w = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (start + k) % n;
      if (k < n && !found && req[idx]) begin
        w = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/seq_run_tracker.sv
// seq_run_tracker: counts runs of RUN_MATCH_LEN equal bits, restarting the run after each hit.
module seq_run_tracker
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit
);
  logic [1:0] run_q;
  logic       prev_q;
  logic       same;
  assign same = run_q != 2'd0 && bit_in == prev_q;
  assign hit  = bit_valid && same && run_q == 2'(RUN_MATCH_LEN - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else if (clr) begin
      run_q <= '0;
    end else if (bit_valid) begin
      run_q  <= !same ? 2'd1 : hit ? 2'd0 : run_q + 2'd1;
      prev_q <= bit_in;
    end
  end
endmodule

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: grants one requester at a time and streams its word MSB-first through a run detector.
// Define SEQ_SCAN_RR_EN for round-robin arbitration; otherwise lowest index wins.
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CNT_W-1:0]         match_cnt
);
  localparam int IDW = $clog2(NREQ);
  localparam int BW  = WORD_W > 1 ? $clog2(WORD_W) : 1;
  state_e            state_q;
  logic [WORD_W-1:0] sh_q;
  logic [BW-1:0]     bit_q;
  logic [IDW-1:0]    id_q, win, done_id_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, match_q;
  logic [NREQ-1:0]   gnt_q;
  logic              done_q, hit, last;
  int                start;
`ifdef SEQ_SCAN_RR_EN
  logic [IDW-1:0]    ptr_q;
  assign start = ptr_q == IDW'(NREQ - 1) ? 0 : int'(ptr_q) + 1;
`else
  assign start = 0;
`endif
  assign win       = IDW'(pick_winner(MAX_REQ'(req), NREQ, start));
  assign last      = bit_q == BW'(WORD_W - 1);
  assign cnt_d     = hit && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
  assign busy      = state_q != IDLE;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_q;
  seq_run_tracker u_trk (
    .clk,
    .reset,
    .clr      (state_q == IDLE),
    .bit_valid(state_q == SHIFT),
    .bit_in   (sh_q[WORD_W-1]),
    .hit
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      match_q   <= '0;
`ifdef SEQ_SCAN_RR_EN
      ptr_q     <= IDW'(NREQ - 1);
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          state_q <= SHIFT;
          gnt_q   <= NREQ'(1) << win;
          sh_q    <= req_data[int'(win)*WORD_W +: WORD_W];
          id_q    <= win;
          bit_q   <= '0;
          cnt_q   <= '0;
`ifdef SEQ_SCAN_RR_EN
          ptr_q   <= win;
`endif
        end
        SHIFT: begin
          sh_q  <= sh_q << 1;
          bit_q <= bit_q + BW'(1);
          cnt_q <= cnt_d;
          if (last) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            match_q   <= cnt_d;
            done_id_q <= id_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// tb_seq_scan_arbiter: directed words with hand-computed counts; a monitor scores grants and results from queues.
module tb_seq_scan_arbiter;
  typedef struct {int id; int cnt;} res_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;
  logic [3:0]  s_req = '0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_gnt;
  logic        s_busy, s_done;
  logic [1:0]  s_id;
  logic [0:0]  s_match;
  int total = 0, bad = 0, cyc = 0;
  res_t rq[$];
  int   gq[$];

  seq_scan_arbiter #(.NREQ(4), .WORD_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt));
  seq_scan_arbiter #(.NREQ(4), .WORD_W(8), .CNT_W(1)) dut_sat (
    .clk(clk), .reset(reset), .req(s_req), .req_data(s_data), .gnt(s_gnt),
    .busy(s_busy), .done(s_done), .done_id(s_id), .match_cnt(s_match));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (|gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
        else chk("gnt_onehot", int'(gnt), 1 << gq.pop_front());
      end
      if (done) begin
        if (rq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          res_t e;
          e = rq.pop_front();
          chk("done_id", int'(done_id), e.id);
          chk("match_cnt", int'(match_cnt), e.cnt);
        end
      end
    end
  end

  task automatic run_word(input int id, input logic [7:0] data, input logic [7:0] mid, input int exp);
    int n;
    @(posedge clk);
    #1;
    req_data[id*8 +: 8] = data;
    req[id] = 1'b1;
    gq.push_back(id);
    rq.push_back('{id, exp});
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[id] && n < 30);
    chk("gnt_latency", n - 1, 1);
    chk("busy_after_gnt", int'(busy), 1);
    @(posedge clk);
    #1;
    req[id] = 1'b0;
    req_data[id*8 +: 8] = mid;
    do begin @(negedge clk); n++; end while (!done && n < 40);
    chk("done_latency", n - 1, 9);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, last;
    #2;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_match", int'(match_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_word(0, 8'h00, 8'h00, 2);
    run_word(1, 8'hAA, 8'hAA, 0);
    run_word(0, 8'h00, 8'hAA, 2);
    run_word(2, 8'hFF, 8'hFF, 2);
    run_word(0, 8'hE3, 8'hE3, 2);
    run_word(3, 8'h3C, 8'h3C, 1);
    @(posedge clk);
    #1;
    req_data[15:8] = 8'h00;
    req[1] = 1'b1;
    gq.push_back(1);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[1] && n < 30);
    chk("abort_gnt", int'(gnt[1]), 1);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_gnt0", int'(gnt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_done_id", int'(done_id), 0);
    chk("abort_match", int'(match_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_word(2, 8'hFF, 8'hFF, 2);
    pulse_reset();
    @(posedge clk);
    #1;
    req_data = '0;
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
`ifdef SEQ_SCAN_RR_EN
      gq.push_back(i % 4);
      rq.push_back('{i % 4, 2});
`else
      gq.push_back(0);
      rq.push_back('{0, 2});
`endif
    end
    last = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(|gnt) && n < 30);
      chk("burst_gnt_seen", int'(|gnt), 1);
      if (g > 0) chk("burst_spacing", cyc - last, 10);
      last = cyc;
    end
    @(posedge clk);
    #1;
    req = '0;
    n = 0;
    while (rq.size() > 0 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    chk("res_queue_drained", rq.size(), 0);
    chk("gnt_queue_drained", gq.size(), 0);
    #1;
    s_data = '0;
    s_req = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_done && n < 30);
    chk("sat_done_seen", int'(s_done), 1);
    chk("sat_match", int'(s_match), 1);
    chk("sat_id", int'(s_id), 0);
    s_req = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
